sram_access_arbiter: RTL

//  Shares the single external SRAM port (address/write-data/we_n into the SRAM controller) among NUM_REQ

---
 rtl/sram_access_arbiter_pkg.sv | 34 +++
 rtl/sram_rr_picker.sv | 28 ++
 rtl/sram_access_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sram_access_arbiter_pkg.sv
// Shared types and constants for the SRAM access arbiter: FSM states,
// requester indices and the mux/read-tag payloads.
package sram_access_arbiter_pkg;

   localparam int unsigned ADDR_W   = 18;
   localparam int unsigned DATA_W   = 16;
   localparam int unsigned COUNT_W  = 18;
   localparam int unsigned TAG_ID_W = 4;

   localparam int unsigned REQ_UART = 0;
   localparam int unsigned REQ_M1   = 1;
   localparam int unsigned REQ_M2   = 2;
   localparam int unsigned REQ_VGA  = 3;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_OWNED,
      ARB_RELEASE
   } sram_arb_state_e;

   // One SRAM access as presented by the current owner
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic              we_n;
   } sram_access_t;

   // Read-return tag travelling alongside the SRAM read latency
   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } rd_tag_t;

endpackage

// File: rtl/sram_rr_picker.sv
// Rotating-priority one-hot select: first asserted request at or above
// the pointer, wrapping around.
module sram_rr_picker #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] pick_c
);

   logic        found;
   int unsigned idx;

   always_comb begin
      pick_c = '0;
      found  = 1'b0;
      idx    = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = (32'(ptr) + i) % NUM_REQ;
         if (!found && req[PTR_W'(idx)]) begin
            pick_c[PTR_W'(idx)] = 1'b1;
            found               = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sram_access_arbiter.sv
// Round-robin burst arbiter for the single external SRAM port, with
// read-data routing, source-region write protection and a write counter.
module sram_access_arbiter
   import sram_access_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned PROTECT_BASE = 76800
) (
   input  logic                             Clock_50,
   input  logic                             Resetn,
   input  logic [NUM_REQ-1:0]               req,
   input  logic [NUM_REQ-1:0]               en,
   input  logic [NUM_REQ-1:0]               we_n,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0]   addr,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]   wdata,
   output logic [NUM_REQ-1:0]               gnt,
   output logic [NUM_REQ-1:0]               rd_valid,
   output logic [ADDR_W-1:0]                SRAM_address,
   output logic [DATA_W-1:0]                SRAM_write_data,
   output logic                             SRAM_we_n,
   output logic                             prot_violation,
   output logic [COUNT_W-1:0]               write_count
);

   localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned PIPE_D = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;

   sram_arb_state_e    state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [NUM_REQ-1:0] gnt_d;
   logic [NUM_REQ-1:0] pick_c;
   logic [PTR_W-1:0]   owner_idx;
   logic               owner_live;

   sram_access_t       acc;
   logic               issue;
   logic [PTR_W-1:0]   iss_idx;
   logic               wr_req;
   logic               blocked;
   logic               wr_issued;
   logic               rd_issued;

   rd_tag_t            issue_tag;
   rd_tag_t            tag_q [PIPE_D];
   rd_tag_t            tag_tail;
   logic [NUM_REQ-1:0] rd_valid_d;

   sram_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_picker (
      .req    (req),
      .ptr    (ptr_q),
      .pick_c (pick_c)
   );

   // Index of the current owner, valid only while gnt is non-zero
   always_comb begin
      owner_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) owner_idx = PTR_W'(i);
      end
   end

   assign owner_live = |(gnt & req);

   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= ARB_IDLE;
         ptr_q   <= '0;
         gnt     <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt     <= gnt_d;
      end
   end

   // Ownership FSM: grants are held until the owner drops req, then one
   // turnaround cycle with the pointer moved past the old owner.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt;
      case (state_q)
         ARB_IDLE: begin
            gnt_d = '0;
            if (|req) begin
               gnt_d   = pick_c;
               state_d = ARB_OWNED;
            end
         end
         ARB_OWNED: begin
            if (!owner_live) begin
               gnt_d   = '0;
               state_d = ARB_RELEASE;
               ptr_d   = (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);
            end
         end
         ARB_RELEASE: begin
            if (|req) begin
               gnt_d   = pick_c;
               state_d = ARB_OWNED;
            end else begin
               gnt_d   = '0;
               state_d = ARB_IDLE;
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = ARB_IDLE;
         end
      endcase
   end

   // Owner mux; the port idles at zero address/data with we_n high
   always_comb begin
      acc      = '0;
      acc.we_n = 1'b1;
      issue    = 1'b0;
      iss_idx  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt[i] && req[i] && en[i]) begin
            issue     = 1'b1;
            iss_idx   = PTR_W'(i);
            acc.addr  = addr[i];
            acc.wdata = wdata[i];
            acc.we_n  = we_n[i];
         end
      end
   end

   // Only the UART loader may write the source-data region
   assign wr_req    = issue && !acc.we_n;
   assign blocked   = wr_req && (acc.addr >= ADDR_W'(PROTECT_BASE))
                      && (iss_idx != PTR_W'(REQ_UART));
   assign wr_issued = wr_req && !blocked;
   assign rd_issued = issue && acc.we_n;

   assign SRAM_address    = acc.addr;
   assign SRAM_write_data = acc.wdata;
   assign SRAM_we_n       = !wr_issued;

   assign issue_tag.valid = rd_issued;
   assign issue_tag.id    = TAG_ID_W'(iss_idx);

   generate
      if (READ_LATENCY > 1) begin : g_tail_pipe
         assign tag_tail = tag_q[PIPE_D-1];
      end else begin : g_tail_direct
         assign tag_tail = issue_tag;
      end
   endgenerate

   always_comb begin
      rd_valid_d = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (tag_tail.valid && (tag_tail.id == TAG_ID_W'(i))) rd_valid_d[i] = 1'b1;
      end
   end

   // Read tags ride alongside the SRAM latency; the last stage is rd_valid
   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn) begin
         for (int unsigned k = 0; k < PIPE_D; k++) tag_q[k] <= '0;
         rd_valid <= '0;
      end else begin
         tag_q[0] <= issue_tag;
         for (int unsigned k = 1; k < PIPE_D; k++) tag_q[k] <= tag_q[k-1];
         rd_valid <= rd_valid_d;
      end
   end

   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn) begin
         prot_violation <= 1'b0;
         write_count    <= '0;
      end else begin
         if (blocked) prot_violation <= 1'b1;
         if (wr_issued && (write_count != '1)) write_count <= write_count + COUNT_W'(1);
      end
   end

endmodule
